// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the double-dabble adjust constants.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_nibble,
   output logic [BCD_DIGIT_W-1:0] o_nibble
);

   // Largest input taking the add is 9, giving 12, so the 4-bit sum never wraps.
   assign o_nibble = (i_nibble >= BCD_ADJ_THRESH) ? i_nibble + BCD_ADJ_ADD : i_nibble;

endmodule

// File: rtl/reg_bcd_converter.sv
// Sequential binary-to-BCD converter: captures the ALU result on start and
// converts it one bit per clock, presenting decimal digits and blank flags.
module reg_bcd_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [WIDTH-1:0]              value,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic [DIGITS-1:0]             blank
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + WIDTH;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   bcd_state_t        r_state;
   bcd_state_t        w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [SR_W-1:0]   r_shift;
   logic [SR_W-1:0]   w_adj;
   logic [SR_W-1:0]   w_shifted;
   logic [BCD_W-1:0]  r_bcd;
   logic [DIGITS-1:0] r_blank;
   logic [DIGITS-1:0] w_blank;
   logic              w_last;

   // Binary bits pass through untouched; only the BCD nibbles are corrected.
   assign w_adj[WIDTH-1:0] = r_shift[WIDTH-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adjust u_adjust (
         .i_nibble (r_shift[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .o_nibble (w_adj[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
   end

   assign w_shifted = w_adj << 1;
   assign w_last    = (r_cnt == CNT_LAST);

   always_comb begin
      w_blank = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (i == DIGITS - 1)
            w_blank[i] = (w_shifted[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
         else
            w_blank[i] = w_blank[i+1] &
                         (w_shifted[WIDTH + BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_bcd   <= '0;
         r_blank <= BLANK_RST;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shift <= {{BCD_W{1'b0}}, value};
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_shift <= w_shifted;
               r_cnt   <= r_cnt + 1'b1;
               // Digits are published only once, so no partial result is ever visible.
               if (w_last) begin
                  r_bcd   <= w_shifted[SR_W-1 -: BCD_W];
                  r_blank <= w_blank;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state != IDLE);
   assign done  = (r_state == DONE);
   assign bcd   = r_bcd;
   assign blank = r_blank;

endmodule

// File: tb/tb_reg_bcd_converter.sv
// Self-checking bench for reg_bcd_converter: directed scenarios plus an
// exhaustive sweep and random values against a decimal reference model.
module tb_reg_bcd_converter;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  start;
   logic [WIDTH-1:0]      value;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     blank;

   int n_vec = 0;
   int n_err = 0;

   reg_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .value (value),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .blank (blank)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits by plain division.
   function automatic logic [31:0] model_bcd(input int v);
      logic [31:0] r = 0;
      int p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r = r | (32'((v / p) % 10) << (4 * i));
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] model_blank(input int v);
      logic [31:0] r = 0;
      int p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         if (v < p) r[i] = 1'b1;
         p = p * 10;
      end
      return r;
   endfunction

   task automatic run_conv(input int v);
      int lat;
      @(negedge clock);
      value = WIDTH'(v);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      check("latency", lat, WIDTH);
      check("bcd", 32'(bcd), model_bcd(v));
      check("blank", 32'(blank), model_blank(v));
      @(negedge clock);
      check("done_one_cycle", 32'(done), 0);
      check("busy_fall", 32'(busy), 0);
   endtask

   initial begin
      int dcnt;
      int t0, t1, t2, n;
      logic [31:0] cap;

      reset = 1'b1;
      start = 1'b0;
      value = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("rst_bcd", 32'(bcd), 0);
      check("rst_blank", 32'(blank), 32'b110);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);

      run_conv(255);
      run_conv(0);
      run_conv(7);
      run_conv(100);

      // Second start during SHIFT with a new value must be ignored.
      @(negedge clock);
      value = 8'd225;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      value = 8'd3;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      dcnt = 0;
      cap  = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dcnt++;
            cap = 32'(bcd);
         end
         @(negedge clock);
      end
      check("ignored_start_dones", dcnt, 1);
      check("ignored_start_bcd", cap, 32'h225);
      check("ignored_start_idle", 32'(busy), 0);

      // Reset mid-conversion: no done pulse, outputs back to reset values.
      @(negedge clock);
      value = 8'd128;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_bcd", 32'(bcd), 0);
      check("abort_blank", 32'(blank), 32'b110);
      check("abort_busy", 32'(busy), 0);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dcnt++;
         @(negedge clock);
      end
      check("abort_no_done", dcnt, 0);
      run_conv(42);

      // Start held high: a restart every WIDTH+2 edges.
      @(negedge clock);
      value = 8'd99;
      start = 1'b1;
      t0 = -1; t1 = -1; t2 = -1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done) begin
            if (n == 0) t0 = i;
            else if (n == 1) t1 = i;
            else if (n == 2) t2 = i;
            n++;
            check("held_bcd", 32'(bcd), 32'h099);
         end
      end
      start = 1'b0;
      check("held_spacing1", t1 - t0, WIDTH + 2);
      check("held_spacing2", t2 - t1, WIDTH + 2);
      n = 0;
      while (busy && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("held_drain", 32'(busy), 0);

      for (int v = 0; v < (1 << WIDTH); v++) run_conv(v);
      for (int i = 0; i < 40; i++) run_conv(int'($urandom_range(0, (1 << WIDTH) - 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
